vga_frame_reader: RTL and testbench

//  Downstream display stage for the camera pipeline. Generates 640x480@60 VGA timing
//  and reads the RGB444 frame buffer written by the camera capture path, which stores
//  12-bit pixels at linear 19-bit address y*640+x. Drives the VGA pins and gates the

---
 rtl/vga_frame_reader_if.sv | 24 ++
 rtl/vga_frame_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_frame_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port and VGA pin bundle for vga_frame_reader.
// master = display stage (drives reads and pins), slave = memory / monitor side.
interface vga_frame_reader_if;
   logic        rd_en;
   logic [18:0] rd_addr;
   logic [11:0] rd_data;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_de;
   logic        frame_start;

   modport master (
      output rd_en, rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start,
      input  rd_data
   );

   modport slave (
      input  rd_en, rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start,
      output rd_data
   );
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA timing generator reading an RGB444 frame buffer, gated by cfg_done per frame.
// Optional macro VGA_TEST_PATTERN_EN adds pattern_sel and an 8-bar colour test pattern.
module vga_frame_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int RD_LAT   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_done,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               pattern_sel,
`endif
   vga_frame_reader_if.master bus
);

   localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_B = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_B = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam int         PIPE     = RD_LAT + 1;
   localparam logic       SYNC_IDLE = ~SYNC_POL;

   // Flag word bits: [0]=hs [1]=vs [2]=de [3]=frame start; pattern build adds [4]=pattern, [7:5]=bar.
`ifdef VGA_TEST_PATTERN_EN
   localparam int FW = 8;

   function automatic logic [2:0] bar_of(input logic [9:0] h);
      logic [2:0] b;
      if      (h < 10'd80)  b = 3'd0;
      else if (h < 10'd160) b = 3'd1;
      else if (h < 10'd240) b = 3'd2;
      else if (h < 10'd320) b = 3'd3;
      else if (h < 10'd400) b = 3'd4;
      else if (h < 10'd480) b = 3'd5;
      else if (h < 10'd560) b = 3'd6;
      else                  b = 3'd7;
      return b;
   endfunction

   function automatic logic [11:0] bar_colour(input logic [2:0] b);
      logic [11:0] c;
      case (b)
         3'd0:    c = 12'hFFF;
         3'd1:    c = 12'hFF0;
         3'd2:    c = 12'h0FF;
         3'd3:    c = 12'h0F0;
         3'd4:    c = 12'hF0F;
         3'd5:    c = 12'hF00;
         3'd6:    c = 12'h00F;
         default: c = 12'h000;
      endcase
      return c;
   endfunction
`else
   localparam int FW = 4;
`endif

   logic [9:0]    h_cnt_q, h_cnt_d;
   logic [9:0]    v_cnt_q, v_cnt_d;
   logic          active0_s, hs0_s, vs0_s, first0_s;
   logic [FW-1:0] flags0_s;
   logic [18:0]   issue_addr_s;
   logic [18:0]   addr_ptr_q, addr_ptr_d;
   logic [18:0]   rd_addr_q, rd_addr_d;
   logic          rd_en_q, rd_en_d;
   logic          show_q, show_d;
   logic [FW-1:0] pipe_q [PIPE];
   logic [FW-1:0] pipe_d [PIPE];
   logic [FW-1:0] pipe_out_s;
   logic [11:0]   rgb_q, rgb_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          de_q, de_d;
   logic          fs_q, fs_d;

   // Scan counters: h wraps at end of line, v advances on each h wrap.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = 10'd0;
         if (v_cnt_q == V_LAST) begin
            v_cnt_d = 10'd0;
         end else begin
            v_cnt_d = v_cnt_q + 10'd1;
         end
      end else begin
         h_cnt_d = h_cnt_q + 10'd1;
      end
   end

   // Stage-0 decode of the scan position into raw timing flags.
   always_comb begin
      active0_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs0_s     = (h_cnt_q >= H_SYNC_B) && (h_cnt_q < H_SYNC_E);
      vs0_s     = (v_cnt_q >= V_SYNC_B) && (v_cnt_q < V_SYNC_E);
      first0_s  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
`ifdef VGA_TEST_PATTERN_EN
      flags0_s  = {bar_of(h_cnt_q), pattern_sel, first0_s, active0_s, vs0_s, hs0_s};
`else
      flags0_s  = {first0_s, active0_s, vs0_s, hs0_s};
`endif
   end

   // Read address: a running pointer restarted at (0,0); rd_addr keeps the last issued value in blanking.
   always_comb begin
      issue_addr_s = first0_s ? 19'd0 : addr_ptr_q;
      if (active0_s) begin
         addr_ptr_d = issue_addr_s + 19'd1;
         rd_addr_d  = issue_addr_s;
      end else begin
         addr_ptr_d = addr_ptr_q;
         rd_addr_d  = rd_addr_q;
      end
`ifdef VGA_TEST_PATTERN_EN
      rd_en_d = active0_s && !pattern_sel;
`else
      rd_en_d = active0_s;
`endif
      if (first0_s) begin
         show_d = cfg_done;
      end else begin
         show_d = show_q;
      end
   end

   // Flag delay line matching the address register plus the memory read latency.
   always_comb begin
      pipe_d[0] = flags0_s;
      for (int i = 1; i < PIPE; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      pipe_out_s = pipe_q[PIPE-1];
   end

   // Pin values: sync polarity applied here, colour gated by de and the per-frame show flag.
   always_comb begin
      hs_d = pipe_out_s[0] ? SYNC_POL : SYNC_IDLE;
      vs_d = pipe_out_s[1] ? SYNC_POL : SYNC_IDLE;
      de_d = pipe_out_s[2];
      fs_d = pipe_out_s[3];
`ifdef VGA_TEST_PATTERN_EN
      if (pipe_out_s[4]) begin
         if (pipe_out_s[2]) begin
            rgb_d = bar_colour(pipe_out_s[7:5]);
         end else begin
            rgb_d = 12'h000;
         end
      end else if (pipe_out_s[2] && show_q) begin
         rgb_d = bus.rd_data;
      end else begin
         rgb_d = 12'h000;
      end
`else
      if (pipe_out_s[2] && show_q) begin
         rgb_d = bus.rd_data;
      end else begin
         rgb_d = 12'h000;
      end
`endif
   end

   // State registers; reset clears the scan immediately and parks the syncs inactive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q    <= 10'd0;
         v_cnt_q    <= 10'd0;
         addr_ptr_q <= 19'd0;
         rd_addr_q  <= 19'd0;
         rd_en_q    <= 1'b0;
         show_q     <= 1'b0;
         for (int i = 0; i < PIPE; i++) begin
            pipe_q[i] <= {FW{1'b0}};
         end
         rgb_q      <= 12'h000;
         hs_q       <= SYNC_IDLE;
         vs_q       <= SYNC_IDLE;
         de_q       <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         addr_ptr_q <= addr_ptr_d;
         rd_addr_q  <= rd_addr_d;
         rd_en_q    <= rd_en_d;
         show_q     <= show_d;
         for (int i = 0; i < PIPE; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
         rgb_q      <= rgb_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         de_q       <= de_d;
         fs_q       <= fs_d;
      end
   end

   assign bus.rd_en       = rd_en_q;
   assign bus.rd_addr     = rd_addr_q;
   assign bus.vga_r       = rgb_q[11:8];
   assign bus.vga_g       = rgb_q[7:4];
   assign bus.vga_b       = rgb_q[3:0];
   assign bus.vga_hs      = hs_q;
   assign bus.vga_vs      = vs_q;
   assign bus.vga_de      = de_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: two shrunken-timing instances (RD_LAT 1 and 2) and one full 640x480 instance.
module tb_vga_frame_reader;
   localparam int HA = 16, HFP = 2, HS = 3, HBP = 3, HT = 24;
   localparam int VA = 4,  VFP = 1, VS = 2, VBP = 1, VT = 8;
   localparam int FT = HT * VT;

   typedef struct packed {
      logic        hs, vs, de, fs, en;
      logic [11:0] rgb;
      logic [18:0] addr;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cfg_done = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   show_m [16];
   logic [11:0] mem_b_s;

   always #5 clk = ~clk;

   vga_frame_reader_if if_a ();
   vga_frame_reader_if if_b ();
   vga_frame_reader_if if_c ();

   // Memory models: rd_data = addr[11:0], one and two cycles after rd_addr is sampled.
   always @(posedge clk) begin
      if_a.rd_data <= if_a.rd_addr[11:0];
      mem_b_s      <= if_b.rd_addr[11:0];
      if_b.rd_data <= mem_b_s;
   end
   assign if_c.rd_data = 12'h000;

   vga_frame_reader #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(1'b0),
`endif
      .bus(if_a));

   vga_frame_reader #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .RD_LAT(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(1'b0),
`endif
      .bus(if_b));

   vga_frame_reader dut_c (
      .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(1'b1),
`endif
      .bus(if_c));

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Expected pins for a shrunken instance in cycle n after reset release.
   function automatic exp_t model_small(input int n, input int lat);
      exp_t e;
      int p, r, h, v;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      p = n - lat - 2;
      if (p >= 0) begin
         r = p % FT; h = r % HT; v = r / HT;
         e.de = (h < HA) && (v < VA);
         e.hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
         e.vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
         e.fs = (r == 0);
         if (e.de && show_m[p / FT]) e.rgb = 12'(v * HA + h);
      end
      p = n - 1;
      if (p >= 0) begin
         r = p % FT; h = r % HT; v = r / HT;
         if ((h < HA) && (v < VA)) begin
            e.en = 1'b1;
            e.addr = 19'(v * HA + h);
         end else if (v < VA) begin
            e.addr = 19'(v * HA + HA - 1);
         end else begin
            e.addr = 19'(VA * HA - 1);
         end
      end
      return e;
   endfunction

   function automatic int bar_exp(input int h);
      case (h / 80)
         0: return 32'hFFF;
         1: return 32'hFF0;
         2: return 32'h0FF;
         3: return 32'h0F0;
         4: return 32'hF0F;
         5: return 32'hF00;
         6: return 32'h00F;
         default: return 32'h000;
      endcase
   endfunction

   task automatic check_small(input string id, input exp_t e, input logic hs, input logic vs,
                              input logic de, input logic fs, input logic [11:0] rgb,
                              input logic en, input logic [18:0] addr);
      check_eq({id, "_hs"}, hs, e.hs);
      check_eq({id, "_vs"}, vs, e.vs);
      check_eq({id, "_de"}, de, e.de);
      check_eq({id, "_fs"}, fs, e.fs);
      check_eq({id, "_rgb"}, rgb, e.rgb);
      check_eq({id, "_en"}, en, e.en);
      check_eq({id, "_addr"}, addr, e.addr);
   endtask

   task automatic check_idle(input string id);
      check_small({id, "_a"}, model_small(0, 1), if_a.vga_hs, if_a.vga_vs, if_a.vga_de,
                  if_a.frame_start, {if_a.vga_r, if_a.vga_g, if_a.vga_b}, if_a.rd_en, if_a.rd_addr);
      check_small({id, "_b"}, model_small(0, 2), if_b.vga_hs, if_b.vga_vs, if_b.vga_de,
                  if_b.frame_start, {if_b.vga_r, if_b.vga_g, if_b.vga_b}, if_b.rd_en, if_b.rd_addr);
   endtask

   // Cycle-by-cycle comparison after a reset release; optionally drops and re-raises cfg_done mid-frame.
   task automatic run_scan(input int ncyc, input bit toggle_cfg);
      int pc, hc;
      bit dc, hsc;
      for (int i = 0; i < 16; i++) show_m[i] = 1'b0;
      show_m[0] = cfg_done;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge clk);
         #1;
         cyc = n;
         if (toggle_cfg && (n == FT + 2 * HT)) cfg_done = 1'b0;
         if (toggle_cfg && (n == 2 * FT + 2 * HT)) cfg_done = 1'b1;
         if ((n % FT) == 0) show_m[n / FT] = cfg_done;
         check_small("a", model_small(n, 1), if_a.vga_hs, if_a.vga_vs, if_a.vga_de,
                     if_a.frame_start, {if_a.vga_r, if_a.vga_g, if_a.vga_b}, if_a.rd_en, if_a.rd_addr);
         check_small("b", model_small(n, 2), if_b.vga_hs, if_b.vga_vs, if_b.vga_de,
                     if_b.frame_start, {if_b.vga_r, if_b.vga_g, if_b.vga_b}, if_b.rd_en, if_b.rd_addr);
         pc = n - 3;
         if (pc >= 0) begin
            hc  = pc % 800;
            dc  = (hc < 640) && ((pc / 800) < 480);
            hsc = !((hc >= 656) && (hc < 752));
         end else begin
            hc  = 0;
            dc  = 1'b0;
            hsc = 1'b1;
         end
         check_eq("c_hs", if_c.vga_hs, hsc);
         check_eq("c_vs", if_c.vga_vs, 1);
         check_eq("c_de", if_c.vga_de, dc);
`ifdef VGA_TEST_PATTERN_EN
         check_eq("c_pat_en", if_c.rd_en, 0);
         check_eq("c_pat_rgb", {if_c.vga_r, if_c.vga_g, if_c.vga_b}, dc ? bar_exp(hc) : 0);
`endif
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_done = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle("rst");
      @(negedge clk);
      rst_n = 1'b1;
      run_scan(8 * FT + 2 * HT + 8, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_scan(300, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
